// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg.sv
// Shared types and constants for the three-requester round-robin arbiter macro.
package gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg;

  localparam int unsigned NREQ = 3;

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_e;

  // Requester index, legal values 1..3.
  typedef logic [1:0] idx_t;

  localparam idx_t RESET_LAST = 2'd3;

  function automatic idx_t oh_to_idx(input logic [NREQ-1:0] oh);
    if (oh[0])      return 2'd1;
    else if (oh[1]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick.sv
// Combinational rotate-priority picker: first request after start_i in order 1,2,3 wins.
module gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick
  import gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg::*;
(
  input  logic [NREQ-1:0] req_i,
  input  idx_t            start_i,
  output logic [NREQ-1:0] gnt_o,
  output logic            valid_o
);

  logic [1:0] pos;

  // Index start_i (1..3) maps to bit position start_i-1, so the next in rotation is bit start_i mod 3.
  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    pos     = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      pos = 2'((32'(start_i) + off) % NREQ);
      if (!valid_o && req_i[pos]) begin
        gnt_o[pos] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3.sv
// Three-requester round-robin arbiter with hold limit and combinational no-request NOR.
// Define GF180MCU_FD_SC_MCU7T5V0_RRARB3_PARK_EN to park the grant on the last owner when idle.
module gf180mcu_fd_sc_mcu7t5v0__rrarb3
  import gf180mcu_fd_sc_mcu7t5v0__rrarb3_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CW       = 4
) (
  input  logic CLK,
  input  logic RN,
  input  logic A1,
  input  logic A2,
  input  logic A3,
  output logic G1,
  output logic G2,
  output logic G3,
  output logic BUSY,
  output logic ZN
);

`ifdef GF180MCU_FD_SC_MCU7T5V0_RRARB3_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  localparam logic [CW-1:0] HOLD_C = CW'(HOLD_MAX);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   g_q, g_d;
  idx_t              last_q, last_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   pick_req;
  logic [NREQ-1:0]   win_oh;
  logic              win_v;
  logic              own_req;

  assign req      = {A3, A2, A1};
  assign own_req  = |(req & g_q);
  // While owning, the owner is excluded so release and forced rotation both pick among the others.
  assign pick_req = (state_q == OWN) ? (req & ~g_q) : req;

  gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick u_pick (
    .req_i   (pick_req),
    .start_i (last_q),
    .gnt_o   (win_oh),
    .valid_o (win_v)
  );

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (PARK && own_req) begin
          // Parked owner reclaims without a latency cycle; grant already high.
          state_d = OWN;
          cnt_d   = ONE_C;
        end else if (win_v) begin
          state_d = OWN;
          g_d     = win_oh;
          last_d  = oh_to_idx(win_oh);
          cnt_d   = ONE_C;
        end else begin
          g_d = PARK ? g_q : '0;
        end
      end
      OWN: begin
        if (!own_req) begin
          if (win_v) begin
            g_d    = win_oh;
            last_d = oh_to_idx(win_oh);
            cnt_d  = ONE_C;
          end else begin
            state_d = IDLE;
            g_d     = PARK ? g_q : '0;
            cnt_d   = '0;
          end
        end else if (cnt_q < HOLD_C) begin
          cnt_d = cnt_q + ONE_C;
        end else if (win_v) begin
          g_d    = win_oh;
          last_d = oh_to_idx(win_oh);
          cnt_d  = ONE_C;
        end
      end
      default: begin
        state_d = IDLE;
        g_d     = '0;
        cnt_d   = '0;
      end
    endcase
    busy_d = (state_d == OWN);
  end

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      g_q     <= '0;
      last_q  <= RESET_LAST;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign G1   = g_q[0];
  assign G2   = g_q[1];
  assign G3   = g_q[2];
  assign BUSY = busy_q;
  assign ZN   = ~(A1 | A2 | A3);

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3.sv
// Scoreboard bench: HOLD_MAX=4 and HOLD_MAX=1 instances against a behavioural arbiter model.
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3;

  logic CLK, RN, A1, A2, A3;
  logic G1a, G2a, G3a, BUSYa, ZNa;
  logic G1b, G2b, G3b, BUSYb, ZNb;

  typedef struct packed {
    logic [2:0] ga;
    logic       ba;
    logic [2:0] gb;
    logic       bb;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   m_own[2];
  int   m_last[2];
  int   m_cnt[2];
  int   hold_of[2] = '{4, 1};

  gf180mcu_fd_sc_mcu7t5v0__rrarb3 #(.HOLD_MAX(4), .CW(4)) u_dut_a (
    .CLK(CLK), .RN(RN), .A1(A1), .A2(A2), .A3(A3),
    .G1(G1a), .G2(G2a), .G3(G3a), .BUSY(BUSYa), .ZN(ZNa)
  );

  gf180mcu_fd_sc_mcu7t5v0__rrarb3 #(.HOLD_MAX(1), .CW(4)) u_dut_b (
    .CLK(CLK), .RN(RN), .A1(A1), .A2(A2), .A3(A3),
    .G1(G1b), .G2(G2b), .G3(G3b), .BUSY(BUSYb), .ZN(ZNb)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] onehot(input int own);
    logic [2:0] v;
    v = 3'b000;
    if (own >= 1 && own <= 3) v[own-1] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_own[i]  = 0;
      m_last[i] = 3;
      m_cnt[i]  = 0;
    end
  endtask

  // One clock edge of the arbiter as described behaviourally.
  task automatic model_step(input int i, input logic [2:0] a);
    logic [2:0] cand;
    logic       own_hi;
    int         w;
    own_hi = (m_own[i] != 0) && a[m_own[i]-1];
    if (own_hi && m_cnt[i] < hold_of[i]) begin
      m_cnt[i]++;
    end else begin
      cand = a;
      if (m_own[i] != 0) cand[m_own[i]-1] = 1'b0;
      w = 0;
      for (int s = 1; s <= 3; s++) begin
        int idx;
        idx = ((m_last[i] + s - 1) % 3) + 1;
        if (w == 0 && cand[idx-1]) w = idx;
      end
      if (w != 0) begin
        m_own[i]  = w;
        m_last[i] = w;
        m_cnt[i]  = 1;
      end else if (!own_hi) begin
        m_own[i] = 0;
        m_cnt[i] = 0;
      end
    end
  endtask

  // Called at a falling edge: drive, predict, wait past the rising edge, compare.
  task automatic drive(input logic [2:0] a);
    exp_t e;
    exp_t got;
    {A3, A2, A1} = a;
    #1;
    check("zn_a", 32'(ZNa), 32'(~|a));
    check("zn_b", 32'(ZNb), 32'(~|a));
    model_step(0, a);
    model_step(1, a);
    e.ga = onehot(m_own[0]);
    e.ba = (m_own[0] != 0);
    e.gb = onehot(m_own[1]);
    e.bb = (m_own[1] != 0);
    sb.push_back(e);
    @(posedge CLK);
    #1;
    got = {G3a, G2a, G1a, BUSYa, G3b, G2b, G1b, BUSYb};
    if (sb.size() == 0) begin
      check("sb_empty", 32'(1), 32'(0));
    end else begin
      e = sb.pop_front();
      check("grant_h4", 32'(got.ga), 32'(e.ga));
      check("busy_h4",  32'(got.ba), 32'(e.ba));
      check("grant_h1", 32'(got.gb), 32'(e.gb));
      check("busy_h1",  32'(got.bb), 32'(e.bb));
    end
    @(negedge CLK);
  endtask

  initial begin
    RN = 1'b0;
    {A3, A2, A1} = 3'b111;
    model_reset();
    #12;
    check("rst_g_a",  32'({G3a, G2a, G1a}), 32'(0));
    check("rst_g_b",  32'({G3b, G2b, G1b}), 32'(0));
    check("rst_busy", 32'({BUSYa, BUSYb}), 32'(0));
    check("rst_zn",   32'(ZNa), 32'(0));
    @(negedge CLK);
    RN = 1'b1;

    for (int i = 0; i < 10; i++) drive(3'b111);
    for (int i = 0; i < 10; i++) drive(3'b010);
    drive(3'b000);
    drive(3'b001);
    drive(3'b101);
    drive(3'b100);
    check("handoff_g3", 32'({G3a, G2a, G1a}), 32'(3'b100));
    drive(3'b000);
    drive(3'b000);
    for (int i = 0; i < 40; i++) drive(3'($urandom_range(0, 7)));
    drive(3'b000);
    for (int i = 0; i < 6; i++) drive(3'b111);

    drive(3'b000);
    drive(3'b100);
    drive(3'b100);
    #2 RN = 1'b0;
    #1;
    check("async_g_a",  32'({G3a, G2a, G1a}), 32'(0));
    check("async_g_b",  32'({G3b, G2b, G1b}), 32'(0));
    check("async_busy", 32'({BUSYa, BUSYb}), 32'(0));
    @(negedge CLK);
    model_reset();
    RN = 1'b1;
    drive(3'b011);
    check("post_rst_g1", 32'({G3a, G2a, G1a}), 32'(3'b001));
    drive(3'b011);
    drive(3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
